coder_lane_packer: RTL and testbench

- Sits directly downstream of the Compressor coder output.
- Consumes the byte stream {idx, byte, last}, where idx selects one of 8 arithmetic-coder lanes.
- Packs each lane's bytes little-endian into 32-bit words and emits a single word stream toward the DMA/host writer.
- At end of stream, flushes every partial lane word, then emits one terminator beat carrying the total byte count.

---
 rtl/coder_lane_packer_if.sv | 32 +++
 rtl/coder_lane_packer.sv | 178 +++++++++++++++++
 tb/tb_coder_lane_packer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coder_lane_packer_if.sv
// Byte-in / word-out stream bundle for the coder lane packer.
// master: coder/host side; slave: packer side.
interface coder_lane_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bits_idx;
    logic [7:0]  in_bits_byte;
    logic        in_bits_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bits_idx;
    logic [31:0] out_bits_data;
    logic [3:0]  out_bits_keep;
    logic        out_bits_last;
    logic        status_busy;

    modport master (
        output in_valid, in_bits_idx, in_bits_byte, in_bits_last,
        output out_ready,
        input  in_ready,
        input  out_valid, out_bits_idx, out_bits_data,
        input  out_bits_keep, out_bits_last, status_busy
    );

    modport slave (
        input  in_valid, in_bits_idx, in_bits_byte, in_bits_last,
        input  out_ready,
        output in_ready,
        output out_valid, out_bits_idx, out_bits_data,
        output out_bits_keep, out_bits_last, status_busy
    );
endinterface

// File: rtl/coder_lane_packer.sv
// Packs 8 coder lanes' bytes little-endian into 32-bit words,
// flushes partial words at end of stream and emits a byte-count beat.
// Ports: clk, rst (sync, active-high), bus (slave modport):
//   in_*  byte stream {idx, byte, last} with valid/ready
//   out_* word stream {idx, data, keep, last} with valid/ready
//   status_busy high while flushing or emitting the terminator
module coder_lane_packer #(
    parameter int         NUM_LANES = 8,
    parameter logic [7:0] TERM_IDX  = 8'hFF
) (
    input logic           clk,
    input logic           rst,
    coder_lane_packer_if.slave bus
);

    typedef enum logic [1:0] {
        S_ACCEPT,
        S_FLUSH,
        S_TERM,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  ptr_q, ptr_d;
    logic [31:0] total_q, total_d;
    logic [31:0] acc_q [NUM_LANES];
    logic [31:0] acc_d [NUM_LANES];
    logic [1:0]  cnt_q [NUM_LANES];
    logic [1:0]  cnt_d [NUM_LANES];

    logic        ov_q, ov_d;
    logic [7:0]  oidx_q, oidx_d;
    logic [31:0] odata_q, odata_d;
    logic [3:0]  okeep_q, okeep_d;
    logic        olast_q, olast_d;

    logic        out_free;
    logic        in_ready;
    logic        fire;
    logic        adv;
    logic [2:0]  lane;
    logic        unused_idx;

    function automatic logic [3:0] keep_of(input logic [1:0] c);
        logic [3:0] k;
        case (c)
            2'd1:    k = 4'b0001;
            2'd2:    k = 4'b0011;
            2'd3:    k = 4'b0111;
            default: k = 4'b0000;
        endcase
        return k;
    endfunction

    assign unused_idx = ^bus.in_bits_idx[7:3];
    assign lane       = bus.in_bits_idx[2:0];
    assign out_free   = !ov_q || bus.out_ready;
    assign in_ready   = !rst && (state_q == S_ACCEPT) && out_free;
    assign fire       = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        total_d = total_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        oidx_d  = oidx_q;
        odata_d = odata_q;
        okeep_d = okeep_q;
        olast_d = olast_q;
        adv     = 1'b0;

        // A handshake retires the beat unless a new load below replaces it.
        if (ov_q && bus.out_ready) begin
            ov_d = 1'b0;
        end

        unique case (state_q)
            S_ACCEPT: begin
                if (fire) begin
                    total_d = total_q + 32'd1;
                    if (cnt_q[lane] == 2'd3) begin
                        ov_d        = 1'b1;
                        oidx_d      = {5'd0, lane};
                        odata_d     = {bus.in_bits_byte, acc_q[lane][23:0]};
                        okeep_d     = 4'b1111;
                        olast_d     = 1'b0;
                        acc_d[lane] = 32'd0;
                        cnt_d[lane] = 2'd0;
                    end else begin
                        acc_d[lane][{cnt_q[lane], 3'b000} +: 8] = bus.in_bits_byte;
                        cnt_d[lane] = cnt_q[lane] + 2'd1;
                    end
                    if (bus.in_bits_last) begin
                        state_d = S_FLUSH;
                        ptr_d   = 3'd0;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q[ptr_q] == 2'd0) begin
                    adv = 1'b1;
                end else if (out_free) begin
                    ov_d         = 1'b1;
                    oidx_d       = {5'd0, ptr_q};
                    odata_d      = acc_q[ptr_q];
                    okeep_d      = keep_of(cnt_q[ptr_q]);
                    olast_d      = 1'b0;
                    acc_d[ptr_q] = 32'd0;
                    cnt_d[ptr_q] = 2'd0;
                    adv          = 1'b1;
                end
                if (adv) begin
                    if (ptr_q == 3'd7) begin
                        state_d = S_TERM;
                    end else begin
                        ptr_d = ptr_q + 3'd1;
                    end
                end
            end
            S_TERM: begin
                if (out_free) begin
                    ov_d    = 1'b1;
                    oidx_d  = TERM_IDX;
                    odata_d = total_q;
                    okeep_d = 4'b1111;
                    olast_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ov_q && bus.out_ready && olast_q) begin
                    total_d = 32'd0;
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ACCEPT;
            ptr_q   <= 3'd0;
            total_q <= 32'd0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_q[i] <= 32'd0;
                cnt_q[i] <= 2'd0;
            end
            ov_q    <= 1'b0;
            oidx_q  <= 8'd0;
            odata_q <= 32'd0;
            okeep_q <= 4'd0;
            olast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            total_q <= total_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            oidx_q  <= oidx_d;
            odata_q <= odata_d;
            okeep_q <= okeep_d;
            olast_q <= olast_d;
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = ov_q;
    assign bus.out_bits_idx  = oidx_q;
    assign bus.out_bits_data = odata_q;
    assign bus.out_bits_keep = okeep_q;
    assign bus.out_bits_last = olast_q;
    assign bus.status_busy   = (state_q == S_FLUSH) || (state_q == S_TERM);

endmodule

// File: tb/tb_coder_lane_packer.sv
// Directed bench for coder_lane_packer.
// Captures every output handshake and compares against hand-built beats.
module tb_coder_lane_packer;

    typedef struct packed {
        logic [7:0]  idx;
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    beat_t q[$];

    coder_lane_packer_if bus ();

    coder_lane_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            q.push_back('{bus.out_bits_idx, bus.out_bits_data,
                          bus.out_bits_keep, bus.out_bits_last});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] idx, input logic [7:0] b,
                        input logic last);
        logic rdy;
        logic ok;
        ok = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_bits_idx  = idx;
        bus.in_bits_byte = b;
        bus.in_bits_last = last;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        bus.in_valid     = 1'b0;
        bus.in_bits_last = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout idx=%h byte=%h not accepted", idx, b);
        end
    endtask

    task automatic wait_term(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (q.size() > 0 && q[q.size()-1].last) found = 1'b1;
            else cycle();
        end
        cycle();
        cycle();
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL %s_term_timeout got beats=%0d want terminator",
                     name, q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.status_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b r=%b busy=%b want 0 0 0",
                     bus.out_valid, bus.in_ready, bus.status_busy);
        end
        checks++;
        if ({bus.out_bits_idx, bus.out_bits_data, bus.out_bits_keep,
             bus.out_bits_last} !== 45'd0) begin
            failures++;
            $display("FAIL reset_bits got idx=%h data=%h keep=%h last=%b want 0",
                     bus.out_bits_idx, bus.out_bits_data,
                     bus.out_bits_keep, bus.out_bits_last);
        end
        rst = 1'b0;
        cycle();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
        end

        // Abort a stream with a partial lane and a stalled full word.
        bus.out_ready = 1'b0;
        send(8'd2, 8'h09, 1'b0);
        send(8'd1, 8'h01, 1'b0);
        send(8'd1, 8'h02, 1'b0);
        send(8'd1, 8'h03, 1'b0);
        send(8'd1, 8'h04, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_valid got %b want 1", bus.out_valid);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid%0d got v=%b r=%b want 0 0",
                         i, bus.out_valid, bus.in_ready);
            end
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        q.delete();
        send(8'd2, 8'hAB, 1'b1);
        wait_term("reset");
        begin
            beat_t e [2];
            e[0] = '{8'd2,   32'h000000AB, 4'h1, 1'b0};
            e[1] = '{8'hFF,  32'd1,        4'hF, 1'b1};
            checks++;
            if (q.size() != 2) begin
                failures++;
                $display("FAIL reset_count got %0d want 2", q.size());
            end
            for (int i = 0; i < 2 && i < q.size(); i++) begin
                checks++;
                if (q[i] !== e[i]) begin
                    failures++;
                    $display("FAIL reset_beat%0d got %h want %h", i, q[i], e[i]);
                end
            end
        end
    endtask

    task automatic test_basic();
        beat_t e [3];
        q.delete();
        send(8'd2, 8'h11, 1'b0);
        send(8'd2, 8'h22, 1'b0);
        send(8'd2, 8'h33, 1'b0);
        send(8'd2, 8'h44, 1'b0);
        send(8'd2, 8'h55, 1'b1);
        checks++;
        if (bus.status_busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_flush got busy=%b r=%b want 1 0",
                     bus.status_busy, bus.in_ready);
        end
        wait_term("basic");
        e[0] = '{8'd2,  32'h44332211, 4'hF, 1'b0};
        e[1] = '{8'd2,  32'h00000055, 4'h1, 1'b0};
        e[2] = '{8'hFF, 32'd5,        4'hF, 1'b1};
        checks++;
        if (q.size() != 3) begin
            failures++;
            $display("FAIL basic_count got %0d want 3", q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                failures++;
                $display("FAIL basic_beat%0d got %h want %h", i, q[i], e[i]);
            end
        end
        checks++;
        if (bus.status_busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_idle got busy=%b r=%b want 0 1",
                     bus.status_busy, bus.in_ready);
        end
    endtask

    task automatic test_single();
        beat_t e [2];
        q.delete();
        send(8'd7, 8'hAA, 1'b1);
        wait_term("single");
        e[0] = '{8'd7,  32'h000000AA, 4'h1, 1'b0};
        e[1] = '{8'hFF, 32'd1,        4'hF, 1'b1};
        checks++;
        if (q.size() != 2) begin
            failures++;
            $display("FAIL single_count got %0d want 2", q.size());
        end
        for (int i = 0; i < 2 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                failures++;
                $display("FAIL single_beat%0d got %h want %h", i, q[i], e[i]);
            end
        end
    endtask

    task automatic test_interleave();
        beat_t e [3];
        q.delete();
        send(8'd0, 8'h01, 1'b0);
        send(8'd5, 8'hA1, 1'b0);
        send(8'd0, 8'h02, 1'b0);
        send(8'd5, 8'hA2, 1'b0);
        send(8'd0, 8'h03, 1'b0);
        send(8'd5, 8'hA3, 1'b1);
        wait_term("ilv");
        e[0] = '{8'd0,  32'h00030201, 4'h7, 1'b0};
        e[1] = '{8'd5,  32'h00A3A2A1, 4'h7, 1'b0};
        e[2] = '{8'hFF, 32'd6,        4'hF, 1'b1};
        checks++;
        if (q.size() != 3) begin
            failures++;
            $display("FAIL ilv_count got %0d want 3", q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                failures++;
                $display("FAIL ilv_beat%0d got %h want %h", i, q[i], e[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        beat_t e [3];
        q.delete();
        bus.out_ready = 1'b0;
        send(8'd6, 8'h11, 1'b0);
        send(8'd6, 8'h12, 1'b0);
        send(8'd6, 8'h13, 1'b0);
        send(8'd6, 8'h14, 1'b0);
        bus.in_valid     = 1'b1;
        bus.in_bits_idx  = 8'd6;
        bus.in_bits_byte = 8'h77;
        bus.in_bits_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_bits_data !== 32'h14131211 ||
                bus.out_bits_idx !== 8'd6 || bus.out_bits_keep !== 4'hF) begin
                failures++;
                $display("FAIL bp_stall%0d got r=%b v=%b idx=%h data=%h keep=%h",
                         i, bus.in_ready, bus.out_valid, bus.out_bits_idx,
                         bus.out_bits_data, bus.out_bits_keep);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(8'd6, 8'h77, 1'b1);
        wait_term("bp");
        e[0] = '{8'd6,  32'h14131211, 4'hF, 1'b0};
        e[1] = '{8'd6,  32'h00000077, 4'h1, 1'b0};
        e[2] = '{8'hFF, 32'd5,        4'hF, 1'b1};
        checks++;
        if (q.size() != 3) begin
            failures++;
            $display("FAIL bp_count got %0d want 3", q.size());
        end
        for (int i = 0; i < 3 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got %h want %h", i, q[i], e[i]);
            end
        end
    endtask

    task automatic test_idx_alias();
        beat_t e [2];
        q.delete();
        send(8'h0B, 8'hC1, 1'b0);
        send(8'h0B, 8'hC2, 1'b0);
        send(8'h0B, 8'hC3, 1'b0);
        send(8'h0B, 8'hC4, 1'b1);
        wait_term("alias");
        e[0] = '{8'd3,  32'hC4C3C2C1, 4'hF, 1'b0};
        e[1] = '{8'hFF, 32'd4,        4'hF, 1'b1};
        checks++;
        if (q.size() != 2) begin
            failures++;
            $display("FAIL alias_count got %0d want 2", q.size());
        end
        for (int i = 0; i < 2 && i < q.size(); i++) begin
            checks++;
            if (q[i] !== e[i]) begin
                failures++;
                $display("FAIL alias_beat%0d got %h want %h", i, q[i], e[i]);
            end
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.in_bits_idx  = 8'd0;
        bus.in_bits_byte = 8'd0;
        bus.in_bits_last = 1'b0;
        bus.out_ready    = 1'b1;
        #1;
        test_reset();
        test_basic();
        test_single();
        test_interleave();
        test_backpressure();
        test_idx_alias();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
